// File: rtl/freq_regulator_p.sv
// freq_regulator_p: measures psi high-time and nudges a clamped divider toward setPeriod.
// Optional proportional step is enabled by defining FREQ_REG_PROP_EN.
module freq_regulator_p #(
  parameter int CNT_W    = 16,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 127,
  parameter int DIV_MIN  = 1,
  parameter int DIV_MAX  = 254,
  parameter int TOL      = 0,
  parameter int LOCK_N   = 4,
  parameter int SHIFT    = 2,
  parameter int STEP_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psi,
  input  logic [CNT_W-1:0] setPeriod,
  output logic             inc,
  output logic             dec,
  output logic             meas_valid,
  output logic [CNT_W-1:0] measured,
  output logic [DIV_W-1:0] adjustedDiv,
  output logic             locked,
  output logic             sat,
  output logic             ovf
);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [7:0] lock_cnt, lock_inc;
  logic fin, full, over, under, sat_hi, sat_lo, sat_n;
  logic signed [CNT_W:0] err, tol;
  logic [DIV_W-1:0] step, div_n;
  logic [DIV_W:0] up;
  assign full = count == {CNT_W{1'b1}};
  assign fin = state == HIGH && !psi;
  assign tol = signed'((CNT_W+1)'(TOL));
  assign err = signed'({1'b0, count}) - signed'({1'b0, setPeriod});
  // A saturated count is treated as too long regardless of the deadband.
  assign over = full || err > tol;
  assign under = !full && err < -tol;
`ifdef FREQ_REG_PROP_EN
  logic [CNT_W:0] mag, shr;
  assign mag = unsigned'(err[CNT_W] ? -err : err);
  assign shr = mag >> SHIFT;
  assign step = DIV_W'(shr > (CNT_W+1)'(STEP_MAX) ? (CNT_W+1)'(STEP_MAX) : shr == '0 ? (CNT_W+1)'(1) : shr);
`else
  assign step = DIV_W'(1);
`endif
  // One extra bit keeps the sum and the lower-bound test free of wrap-around.
  assign up = {1'b0, adjustedDiv} + {1'b0, step};
  assign sat_hi = up > (DIV_W+1)'(DIV_MAX);
  assign sat_lo = {1'b0, adjustedDiv} < {1'b0, step} + (DIV_W+1)'(DIV_MIN);
  assign div_n = over ? (sat_hi ? DIV_W'(DIV_MAX) : up[DIV_W-1:0])
               : under ? (sat_lo ? DIV_W'(DIV_MIN) : adjustedDiv - step) : adjustedDiv;
  assign sat_n = over ? sat_hi : under && sat_lo;
  assign lock_inc = lock_cnt == 8'(LOCK_N) ? lock_cnt : lock_cnt + 8'd1;
  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      SYNC: state_n = psi ? SYNC : IDLE;
      IDLE: begin
        state_n = psi ? HIGH : IDLE;
        count_n = psi ? CNT_W'(1) : count;
      end
      HIGH: begin
        state_n = psi ? HIGH : IDLE;
        count_n = psi && !full ? count + CNT_W'(1) : count;
      end
      default: state_n = SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SYNC;
      count <= '0;
      lock_cnt <= '0;
      measured <= '0;
      adjustedDiv <= DIV_W'(DIV_INIT);
      inc <= 1'b0;
      dec <= 1'b0;
      meas_valid <= 1'b0;
      locked <= 1'b0;
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      meas_valid <= fin;
      inc <= fin && over;
      dec <= fin && under;
      sat <= fin && sat_n;
      ovf <= fin && full;
      if (fin) begin
        measured <= count;
        adjustedDiv <= div_n;
        lock_cnt <= over || under ? 8'd0 : lock_inc;
        locked <= !(over || under) && lock_inc == 8'(LOCK_N);
      end
    end
  end
endmodule

// File: doc/freq_regulator_p.md
Name: freq_regulator_p

Overview:
- Parametrised successor of the single-channel frequency regulator.
- Measures the high-time of a sampled pulse input `psi` in clock cycles and compares it with a programmable set period.
- Nudges a divider value up or down toward lock, with a tolerance deadband, divider clamping, counter-overflow detection, lock detection and an optional proportional step.
- Sits between the pulse source (divided oscillator feedback) and the clock divider it steers.

Parameters:
- CNT_W, 16, width of the pulse-width counter, `setPeriod` and `measured`
- DIV_W, 8, width of `adjustedDiv`
- DIV_INIT, 127, reset value of `adjustedDiv`
- DIV_MIN, 1, lower clamp of `adjustedDiv`
- DIV_MAX, 254, upper clamp of `adjustedDiv`
- TOL, 0, deadband: abs(error) <= TOL counts as in-band
- LOCK_N, 4, consecutive in-band measurements required to assert `locked` (1..255)
- SHIFT, 2, proportional right-shift (used only with the optional feature)
- STEP_MAX, 16, proportional step ceiling (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- psi  in  1  pulse input, already synchronous to `clk`
- setPeriod  in  CNT_W  target high-time in cycles, unsigned
- inc  out  1  one-cycle pulse: divider increased
- dec  out  1  one-cycle pulse: divider decreased
- meas_valid  out  1  one-cycle pulse: new `measured` value
- measured  out  CNT_W  last high-time in cycles
- adjustedDiv  out  DIV_W  divider value
- locked  out  1  LOCK_N consecutive in-band measurements seen
- sat  out  1  one-cycle pulse: adjustment was clamped at DIV_MIN or DIV_MAX
- ovf  out  1  one-cycle pulse: measurement saturated the counter

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=SYNC, count=0, lock_cnt=0.
  - `adjustedDiv`=DIV_INIT, `measured`=0.
  - `inc`, `dec`, `meas_valid`, `locked`, `sat`, `ovf` all 0.
- All state updates on rising `clk`. `psi` is sampled at each edge.
- FSM states:
  - SYNC: wait for `psi`=0, then go to IDLE. A pulse already high when reset is released is discarded.
  - IDLE: on `psi`=1, set count<=1 and go to HIGH.
  - HIGH, `psi`=1: count<=count+1, saturating at 2^CNT_W-1.
  - HIGH, `psi`=0: finalise the measurement and go to IDLE.
- Measurement value = number of consecutive edges at which `psi` was sampled 1.
- Finalise (all at the same edge that samples `psi`=0):
  - `measured`<=count and `meas_valid`=1.
  - `ovf`=1 if count==2^CNT_W-1.
  - Error e = count - `setPeriod`, evaluated signed at CNT_W+1 bits.
  - e > TOL: divider += step and `inc`=1.
  - e < -TOL: divider -= step and `dec`=1.
  - Otherwise (in-band): no divider change.
  - An overflowed measurement always takes the e > TOL path.
- Step: 1 (see Optional Feature).
- Clamping:
  - The divider result is clamped to [DIV_MIN, DIV_MAX]. Arithmetic is done at DIV_W+1 bits, so there is no wrap-around.
  - If clamped, `sat`=1. `inc`/`dec` still pulse.
  - If `adjustedDiv` already sits at the limit, its value is unchanged.
- Lock:
  - In-band measurement: lock_cnt increments, saturating at LOCK_N. `locked`=1 when lock_cnt reaches LOCK_N, at that same edge.
  - Out-of-band measurement: lock_cnt and `locked` are cleared at that edge.
- Pulse outputs (`inc`, `dec`, `meas_valid`, `sat`, `ovf`) are high for exactly one cycle. `inc` and `dec` are never high together.
- `setPeriod` may change at any time. It is used only at the finalise edge.
- Back-to-back pulses (one low cycle between them) are all measured. The low edge that finalises also leaves the FSM in IDLE, so the next high sample starts a new count.
- Reset mid-pulse: everything returns to reset values. Measurement resumes only after `psi` is seen low.

Optional Feature:
- Macro: FREQ_REG_PROP_EN.
- Defined: step = min(STEP_MAX, max(1, abs(e) >> SHIFT)), truncated to DIV_W bits before clamping.
- Undefined: step is fixed at 1. Parameters SHIFT and STEP_MAX are unused.

Test Plan:
- Reset with `psi`=1, hold `psi` high 5 cycles, then low → no `meas_valid` (partial pulse discarded); `adjustedDiv`=127.
- `setPeriod`=8, pulse high 10 edges → `measured`=10, `meas_valid`, `inc` pulse, `adjustedDiv` 127→128, `locked`=0.
- `setPeriod`=8, TOL=0, four pulses of 8 → no `inc`/`dec`; `locked` rises at the 4th finalise edge. A fifth pulse of 6 → `dec`, `adjustedDiv`−1, `locked` cleared at the same edge.
- DIV_INIT=254, `setPeriod`=2, pulse 20 → `inc`, `sat`, `adjustedDiv` stays 254. Repeat with DIV_INIT=1 and pulse 1 vs `setPeriod`=5 → `dec`, `sat`, stays 1.
- CNT_W=4, `psi` high 20 cycles → `measured`=15, `ovf` and `inc` pulse.
- With FREQ_REG_PROP_EN: `setPeriod`=8, pulse 40 → e=32, step 8, `adjustedDiv` 127→135. Pulse 200 → step clamped to 16.
